pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline stage register for the CPU pipeline, the generic successor to the fixed IF/ID latch. It carries a DATA_W-bit payload between two stages using a valid/ready handshake instead of a bare write enable. It supports synchronous flush to a bubble and an optional two-entry skid buffer that breaks the combinational ready path. A saturating stall counter is provided for performance monitoring.

## Interface
- DATA_W, 64, payload width (e.g. {pc_plus4, instr} for IF/ID)
- BUBBLE, {DATA_W{1'b0}}, payload value driven on reset and flush
- CNT_W, 16, stall counter width
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous flush, highest priority after reset
- in_valid  input  1  upstream payload valid
- in_ready  output  1  stage can accept a payload this cycle
- in_data  input  DATA_W  upstream payload
- out_valid  output  1  downstream payload valid
- out_ready  input  1  downstream accepts this cycle
- out_data  output  DATA_W  payload to next stage
- occupancy  output  2  number of held entries (0..2)
- stall_count  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives out_data/out_valid), skid register (skid build only).
- States: EMPTY (occupancy 0), FULL (1), SKID (2, skid build only).
- EMPTY: in_fire -> FULL, main <= in_data.
- FULL: in_fire & out_fire -> FULL, main <= in_data. in_fire & !out_fire -> SKID, skid <= in_data. !in_fire & out_fire -> EMPTY, main <= BUBBLE. Neither -> hold.
- SKID: in_ready=0. out_fire -> FULL, main <= skid, skid <= BUBBLE. Otherwise hold.
- Flush: next state EMPTY, main and skid <= BUBBLE, out_valid=0. Flush overrides any concurrent in_fire or out_fire. An input accepted in a flush cycle is discarded.
- out_data equals BUBBLE whenever out_valid=0.
- stall_count increments by 1 each cycle with out_valid & !out_ready. It holds at 2^CNT_W-1. It is cleared only by reset; flush does not clear it.
- Payload is never modified; ordering is strictly FIFO.

## Timing
- Reset (async assert): state EMPTY, out_valid=0, out_data=BUBBLE, occupancy=0, stall_count=0. in_ready=1 in the skid build; in the no-skid build in_ready=1 because out_valid=0.
- Latency: in_fire at edge N -> out_valid=1 and out_data valid after edge N, visible in cycle N+1.
- Throughput: one transfer per cycle when out_ready is held at 1.
- Skid build: in_ready = (state != SKID), a pure register output with no combinational path from out_ready.
- Reset deasserting mid-stream: the first edge after deassertion behaves as from EMPTY.
- Flush and reset together: reset dominates; the result is identical.

## Configuration
- PIPE_STAGE_SKID_EN defined: skid register and SKID state are present, occupancy ranges 0..2, and in_ready is registered.
- PIPE_STAGE_SKID_EN undefined: no skid register, occupancy ranges 0..1, and in_ready = !out_valid | out_ready (combinational). The behaviour is equivalent to the legacy stall/flush latch driven by a handshake.

## Test plan
- Reset sequence: assert reset mid-cycle with occupancy 2 -> immediately out_valid=0, out_data=0, occupancy=0, stall_count=0.
- Streaming: in_valid=1 with in_data 1,2,3,4, out_ready=1 -> out_data 1,2,3,4 on consecutive cycles, each one cycle after input, in_ready stays 1.
- Backpressure (skid build): send 0xA, 0xB with out_ready=0 -> occupancy 2, in_ready=0. Release out_ready -> outputs 0xA then 0xB, and in_ready returns to 1 after 0xA leaves.
- Backpressure (no-skid build): out_valid=1, out_ready=0 -> in_ready=0 in the same cycle. Raise out_ready -> in_ready=1 in the same cycle.
- Flush: occupancy 2, assert flush with in_valid=1 and in_data 0x55 -> next cycle occupancy=0, out_valid=0, and 0x55 never appears.
- Counter saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_count=15 and stays 15. A subsequent flush leaves it at 15.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready pipeline stage register.
// Carries a DATA_W-bit payload between two pipeline stages, supports a
// synchronous flush back to a bubble, and keeps a saturating count of
// cycles in which the downstream stage stalled a valid payload.
// Optional feature macro: PIPE_STAGE_SKID_EN adds a second (skid) entry
// so that in_ready becomes a registered signal with no combinational path
// from out_ready.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1 on the same side; valid must not depend on ready, and payload
// order through the stage is strictly first-in first-out.
module pipe_stage_reg #(
  parameter int                 DATA_W = 64,
  parameter logic [DATA_W-1:0]  BUBBLE = '0,
  parameter int                 CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count
);

  // The encoding equals the number of held entries, so occupancy doubles
  // as the externally visible state of the FSM.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_fire, out_fire;

  assign out_valid   = (state_q != EMPTY);
  // main_q is forced to BUBBLE whenever the stage drains or flushes, so
  // out_data already reads BUBBLE whenever out_valid is low.
  assign out_data    = main_q;
  assign occupancy   = state_q;
  assign stall_count = cnt_q;
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q;

  assign in_ready = in_ready_q;

  // Skid entry and registered ready; ready drops only while both entries are held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_q     <= BUBBLE;
      in_ready_q <= 1'b1;
    end else begin
      skid_q     <= skid_d;
      in_ready_q <= (state_d != SKID);
    end
  end
`else
  // Without a skid entry the stage can only accept when it is empty or
  // is being drained in the same cycle.
  assign in_ready = ~out_valid | out_ready;
`endif

  // State, main payload and stall counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and payload movement; flush discards everything, including
  // a payload accepted in the same cycle.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_d  = skid_q;
`endif
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
`ifdef PIPE_STAGE_SKID_EN
      skid_d  = BUBBLE;
`endif
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = FULL;
            main_d  = in_data;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
`ifdef PIPE_STAGE_SKID_EN
          end else if (in_fire) begin
            state_d = SKID;
            skid_d  = in_data;
`endif
          end else if (out_fire) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        SKID: begin
          if (out_fire) begin
            state_d = FULL;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end
        end
`endif
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE;
        end
      endcase
    end
  end

  // Stall counter: saturates at all-ones and is cleared only by reset.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

endmodule
